regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Write-back stage directly upstream of the dual-port register-file RAM.
- Accepts result writes from two execution sources over valid/ready handshakes and buffers each source in its own FIFO.
- Round-robin arbitration issues at most one registered write per cycle on the RAM's write port A. Port A has write priority in the RAM, so it is the only port used.
- Writes to address 0 are absorbed and never reach the RAM.

Parameters:
DATA_WIDTH, 32, width of result data.
ADDR_WIDTH, 8, register-file address width.
FIFO_DEPTH, 4, entries per source FIFO; power of two, minimum 2.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
s0_valid  input  1  source 0 write request.
s0_ready  output  1  source 0 FIFO can accept.
s0_addr  input  ADDR_WIDTH  source 0 destination address.
s0_data  input  DATA_WIDTH  source 0 write data.
s1_valid  input  1  source 1 write request.
s1_ready  output  1  source 1 FIFO can accept.
s1_addr  input  ADDR_WIDTH  source 1 destination address.
s1_data  input  DATA_WIDTH  source 1 write data.
we_a  output  1  RAM write enable, registered.
addr_wr_a  output  ADDR_WIDTH  RAM write address, registered.
data_in_a  output  DATA_WIDTH  RAM write data, registered.
idle  output  1  both FIFOs empty and we_a low.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: FIFOs empty, occupancy counters 0, rr pointer 0, we_a 0, addr_wr_a 0, data_in_a 0. idle is 1 the cycle after reset.
- s*_ready while rst is high: forced 0.
- s*_ready otherwise: equals !full of the source's FIFO. It depends only on the registered count, with no combinational path from valid.
- Handshake: a transfer occurs on a rising edge where valid && ready.
  - Addr != 0: enqueue the transfer.
  - Addr == 0: complete the handshake, discard the transfer, leave occupancy unchanged.
- Per source: FIFO with read and write pointers (log2(FIFO_DEPTH) bits, wrapping modulo depth) and a count of log2(FIFO_DEPTH)+1 bits.
- Full FIFO: push is blocked even if a pop happens in the same cycle, because ready is registered-based.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- Arbitration is evaluated every cycle on FIFO non-empty flags:
  - Both non-empty: grant the source indicated by rr (0 → s0, 1 → s1). rr then becomes the other source.
  - Only one non-empty: grant that source. rr becomes the other source.
  - Neither non-empty: no grant, rr holds.
- Grant: pops the FIFO head. On the same edge, we_a<=1, addr_wr_a<=head addr, data_in_a<=head data.
- No grant: we_a<=0. addr_wr_a and data_in_a hold their last values.
- Latency: an entry accepted into an empty FIFO at edge N, with no contention, drives we_a high after edge N+1. The RAM commits it at edge N+2.
- Throughput: one write per cycle sustained. Under continuous contention, grants alternate s0, s1, s0, ...
- Ordering: per-source FIFO order is preserved. Cross-source order is set only by arbitration.
- Same address in flight from both sources: both writes are issued, and the last-issued one wins.
- Reset mid-operation: all buffered entries are dropped. we_a is 0 the cycle after the reset edge. No partial write is issued.
- idle: combinational, equals (count0==0) && (count1==0) && !we_a.

Optional Feature:
- Macro: WB_HAZARD_EN.
- Defined: adds inputs rd_addr_a and rd_addr_b (ADDR_WIDTH) and outputs hazard_a and hazard_b (1 bit).
  - hazard_x is combinational.
  - hazard_x is high when rd_addr_x != 0 and it equals the addr of any occupied entry in either FIFO, or equals addr_wr_a while we_a=1.
  - Decode uses hazard_x to stall a read until the pending write lands.
- Undefined: these ports and their logic are absent. The remaining behaviour is identical.

Test Plan:
- Reset, then idle with no valids: s0_ready=s1_ready=1, we_a=0, idle=1.
- Single write, s0 addr=5 data=0xDEADBEEF accepted at edge N: we_a=1, addr_wr_a=5, data_in_a=0xDEADBEEF after edge N+1 for exactly one cycle. idle=0 until we_a returns to 0.
- Address-zero drop: s1 addr=0 data=0x1234 handshakes (ready=1). we_a stays 0, count1 stays 0.
- Contention: 3 writes pushed to each source (s0 addr 1,2,3; s1 addr 9,10,11) while both hold valid. Issue order is 1,9,2,10,3,11 on 6 consecutive cycles.
- Backpressure: hold s0_valid high for FIFO_DEPTH+2 cycles while s1 keeps its FIFO non-empty, so grants alternate. s0_ready drops to 0 once 4 entries are held. No entry is lost or duplicated, and issue order matches push order.
- Mid-operation reset: with 2 entries in each FIFO, pulse rst for one cycle. we_a=0 afterwards, no further writes, idle=1. With WB_HAZARD_EN defined: after pushing addr 7, hazard_a=1 for rd_addr_a=7 until the cycle after its we_a pulse. hazard_a=0 for rd_addr_a=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two buffered sources, round-robin onto register-file write port A.
// Optional read-hazard detection is compiled in with `define WB_HAZARD_EN.

module regfile_wb_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int PW = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
`ifdef WB_HAZARD_EN
    input  logic [ADDR_WIDTH-1:0] look_a,
    input  logic [ADDR_WIDTH-1:0] look_b,
    output logic                  hit_a,
    output logic                  hit_b,
`endif
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [PW:0]           count
);
    logic [ADDR_WIDTH-1:0] mem_addr_r [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_r [FIFO_DEPTH];
    logic [PW-1:0]         wptr_r;
    logic [PW-1:0]         rptr_r;
    logic [PW:0]           count_r;

    // Entry storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_r[wptr_r] <= wr_addr;
            mem_data_r[wptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push) begin
                wptr_r <= wptr_r + 1'b1;
            end
            if (pop) begin
                rptr_r <= rptr_r + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_addr = mem_addr_r[rptr_r];
    assign head_data = mem_data_r[rptr_r];
    assign count     = count_r;

`ifdef WB_HAZARD_EN
    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            hit_a = hit_a | (({1'b0, PW'(i) - rptr_r} < count_r) && (mem_addr_r[i] == look_a));
            hit_b = hit_b | (({1'b0, PW'(i) - rptr_r} < count_r) && (mem_addr_r[i] == look_b));
        end
    end
`endif
endmodule

module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [ADDR_WIDTH-1:0] s0_addr,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [ADDR_WIDTH-1:0] s1_addr,
    input  logic [DATA_WIDTH-1:0] s1_data,
`ifdef WB_HAZARD_EN
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  hazard_a,
    output logic                  hazard_b,
`endif
    output logic                  we_a,
    output logic [ADDR_WIDTH-1:0] addr_wr_a,
    output logic [DATA_WIDTH-1:0] data_in_a,
    output logic                  idle
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    logic [PW:0]           count0_s, count1_s;
    logic [ADDR_WIDTH-1:0] head0_addr_s, head1_addr_s;
    logic [DATA_WIDTH-1:0] head0_data_s, head1_data_s;
    logic                  push0_s, push1_s;
    logic                  grant0_s, grant1_s;
    logic                  ne0_s, ne1_s;
    logic                  rr_r;
    logic                  we_a_r;
    logic [ADDR_WIDTH-1:0] addr_wr_a_r;
    logic [DATA_WIDTH-1:0] data_in_a_r;

    assign s0_ready = !rst && (count0_s != FULL_COUNT);
    assign s1_ready = !rst && (count1_s != FULL_COUNT);

    // Address-zero transfers complete the handshake but are never stored.
    assign push0_s = s0_valid && s0_ready && (s0_addr != {ADDR_WIDTH{1'b0}});
    assign push1_s = s1_valid && s1_ready && (s1_addr != {ADDR_WIDTH{1'b0}});

    assign ne0_s    = (count0_s != '0);
    assign ne1_s    = (count1_s != '0);
    assign grant0_s = ne0_s && (!ne1_s || !rr_r);
    assign grant1_s = ne1_s && (!ne0_s || rr_r);

`ifdef WB_HAZARD_EN
    logic hit0_a_s, hit0_b_s, hit1_a_s, hit1_b_s;
`endif

    regfile_wb_fifo #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo0 (
        .clk(clk), .rst(rst), .push(push0_s), .pop(grant0_s),
        .wr_addr(s0_addr), .wr_data(s0_data),
`ifdef WB_HAZARD_EN
        .look_a(rd_addr_a), .look_b(rd_addr_b), .hit_a(hit0_a_s), .hit_b(hit0_b_s),
`endif
        .head_addr(head0_addr_s), .head_data(head0_data_s), .count(count0_s)
    );

    regfile_wb_fifo #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo1 (
        .clk(clk), .rst(rst), .push(push1_s), .pop(grant1_s),
        .wr_addr(s1_addr), .wr_data(s1_data),
`ifdef WB_HAZARD_EN
        .look_a(rd_addr_a), .look_b(rd_addr_b), .hit_a(hit1_a_s), .hit_b(hit1_b_s),
`endif
        .head_addr(head1_addr_s), .head_data(head1_data_s), .count(count1_s)
    );

    // Write port and round-robin pointer; rr always points away from the last winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_r        <= 1'b0;
            we_a_r      <= 1'b0;
            addr_wr_a_r <= '0;
            data_in_a_r <= '0;
        end else if (grant0_s) begin
            rr_r        <= 1'b1;
            we_a_r      <= 1'b1;
            addr_wr_a_r <= head0_addr_s;
            data_in_a_r <= head0_data_s;
        end else if (grant1_s) begin
            rr_r        <= 1'b0;
            we_a_r      <= 1'b1;
            addr_wr_a_r <= head1_addr_s;
            data_in_a_r <= head1_data_s;
        end else begin
            we_a_r      <= 1'b0;
        end
    end

    assign we_a      = we_a_r;
    assign addr_wr_a = addr_wr_a_r;
    assign data_in_a = data_in_a_r;
    assign idle      = (count0_s == '0) && (count1_s == '0) && !we_a_r;

`ifdef WB_HAZARD_EN
    assign hazard_a = (rd_addr_a != {ADDR_WIDTH{1'b0}}) &&
                      (hit0_a_s || hit1_a_s || (we_a_r && (addr_wr_a_r == rd_addr_a)));
    assign hazard_b = (rd_addr_b != {ADDR_WIDTH{1'b0}}) &&
                      (hit0_b_s || hit1_b_s || (we_a_r && (addr_wr_a_r == rd_addr_b)));
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; hazard checks are included when WB_HAZARD_EN is defined.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int D  = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } item_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s0_valid = 1'b0, s1_valid = 1'b0;
    logic          s0_ready, s1_ready;
    logic [AW-1:0] s0_addr = '0, s1_addr = '0;
    logic [DW-1:0] s0_data = '0, s1_data = '0;
    logic          we_a, idle;
    logic [AW-1:0] addr_wr_a;
    logic [DW-1:0] data_in_a;
`ifdef WB_HAZARD_EN
    logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0;
    logic          hazard_a, hazard_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus queues, reference model state and expected-write scoreboard.
    item_t stim0[$], stim1[$];
    item_t q0[$], q1[$];
    item_t exp_q[$];
    logic          rr = 1'b0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic          took0 = 1'b0, took1 = 1'b0;
    logic          bubbles = 1'b0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
`ifdef WB_HAZARD_EN
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
`endif
        .we_a(we_a), .addr_wr_a(addr_wr_a), .data_in_a(data_in_a), .idle(idle)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic item_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d);
        item_t it;
        it.a = a;
        it.d = d;
        return it;
    endfunction

    function automatic logic model_hazard(input logic [AW-1:0] r);
        logic h = 1'b0;
        if (r != '0) begin
            foreach (q0[i]) if (q0[i].a == r) h = 1'b1;
            foreach (q1[i]) if (q1[i].a == r) h = 1'b1;
            if (m_we && m_addr == r) h = 1'b1;
        end
        return h;
    endfunction

    // Reference model: arbitration on pre-edge occupancy, then accepted pushes.
    always @(posedge clk) begin
        logic rdy0, rdy1;
        item_t e;
        took0 = 1'b0;
        took1 = 1'b0;
        if (rst) begin
            q0.delete(); q1.delete(); exp_q.delete();
            rr = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            rdy0 = q0.size() < D;
            rdy1 = q1.size() < D;
            m_we = 1'b0;
            if (q0.size() != 0 && (q1.size() == 0 || rr == 1'b0)) begin
                e = q0.pop_front(); rr = 1'b1; m_we = 1'b1;
            end else if (q1.size() != 0) begin
                e = q1.pop_front(); rr = 1'b0; m_we = 1'b1;
            end
            if (m_we) begin
                m_addr = e.a; m_data = e.d;
                exp_q.push_back(e);
            end
            if (s0_valid && rdy0) begin
                took0 = 1'b1;
                if (s0_addr != '0) q0.push_back(mk(s0_addr, s0_data));
            end
            if (s1_valid && rdy1) begin
                took1 = 1'b1;
                if (s1_addr != '0) q1.push_back(mk(s1_addr, s1_data));
            end
        end
    end

    // Driver: retire accepted items and present the next ones.
    always begin
        @(negedge clk);
        #1;
        if (took0 && stim0.size() != 0) void'(stim0.pop_front());
        if (took1 && stim1.size() != 0) void'(stim1.pop_front());
        if (stim0.size() != 0 && (!bubbles || $urandom_range(0, 3) != 0)) begin
            s0_valid = 1'b1; s0_addr = stim0[0].a; s0_data = stim0[0].d;
        end else begin
            s0_valid = 1'b0; s0_addr = AW'($urandom); s0_data = $urandom;
        end
        if (stim1.size() != 0 && (!bubbles || $urandom_range(0, 3) != 0)) begin
            s1_valid = 1'b1; s1_addr = stim1[0].a; s1_data = stim1[0].d;
        end else begin
            s1_valid = 1'b0; s1_addr = AW'($urandom); s1_data = $urandom;
        end
`ifdef WB_HAZARD_EN
        rd_addr_a = AW'($urandom_range(0, 15));
        rd_addr_b = AW'($urandom_range(0, 15));
`endif
    end

    // Monitor: compare DUT outputs against the model and pop the scoreboard on each write.
    always @(negedge clk) begin
        item_t e;
        check("we_a", {63'd0, we_a}, {63'd0, m_we});
        if (we_a === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {addr_wr_a, data_in_a}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_addr_data", {24'd0, addr_wr_a, data_in_a}, {24'd0, e.a, e.d});
            end
        end
        check("port_hold", {24'd0, addr_wr_a, data_in_a}, {24'd0, m_addr, m_data});
        check("s0_ready", {63'd0, s0_ready}, {63'd0, (!rst && q0.size() < D)});
        check("s1_ready", {63'd0, s1_ready}, {63'd0, (!rst && q1.size() < D)});
        check("idle", {63'd0, idle}, {63'd0, (q0.size() == 0 && q1.size() == 0 && !m_we)});
`ifdef WB_HAZARD_EN
        check("hazard_a", {63'd0, hazard_a}, {63'd0, model_hazard(rd_addr_a)});
        check("hazard_b", {63'd0, hazard_b}, {63'd0, model_hazard(rd_addr_b)});
`endif
    end

    task automatic drain();
        logic done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            #2;
            done = (stim0.size() == 0 && stim1.size() == 0 &&
                    q0.size() == 0 && q1.size() == 0 && !m_we);
        end
        check("drain_timeout", {63'd0, done}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        stim0.push_back(mk(8'd5, 32'hDEADBEEF));
        drain();

        stim1.push_back(mk(8'd0, 32'h0000_1234));
        drain();

        for (int i = 0; i < 3; i++) begin
            stim0.push_back(mk(AW'(i + 1), 32'hA000_0000 + 32'(i)));
            stim1.push_back(mk(AW'(i + 9), 32'hB000_0000 + 32'(i)));
        end
        drain();

        for (int i = 0; i < D + 2; i++) begin
            stim0.push_back(mk(AW'(i + 20), 32'hC000_0000 + 32'(i)));
            stim1.push_back(mk(AW'(i + 40), 32'hD000_0000 + 32'(i)));
        end
        drain();

        bubbles = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #2;
            if (stim0.size() < 6 && $urandom_range(0, 2) != 0)
                stim0.push_back(mk(AW'($urandom_range(0, 15)), $urandom));
            if (stim1.size() < 6 && $urandom_range(0, 2) != 0)
                stim1.push_back(mk(AW'($urandom_range(0, 15)), $urandom));
        end
        drain();
        bubbles = 1'b0;

        for (int i = 0; i < 3; i++) begin
            stim0.push_back(mk(AW'(i + 60), $urandom));
            stim1.push_back(mk(AW'(i + 70), $urandom));
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        stim0.delete();
        stim1.delete();
        repeat (5) @(posedge clk);
        #2;
        check("post_reset_idle", {63'd0, idle}, 64'd1);
        check("post_reset_we", {63'd0, we_a}, 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
